// File: rtl/pmem_stream_loader_if.sv
//--------------------------------------------------------------------
// Module      : pmem_stream_loader_if
// Description : Bus bundle for pmem_stream_loader: load control, byte
//               stream handshake, status and CPU fetch read port.
// Revision    : 1.0 - initial release
//--------------------------------------------------------------------
`default_nettype none

interface pmem_stream_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic                i_load_start;
    logic [ADDR_W-1:0]   i_load_base;
    logic [ADDR_W:0]     i_load_len;
    logic                i_byte_valid;
    logic [7:0]          i_byte;
    logic                o_byte_ready;
    logic                o_busy;
    logic                o_done;
    logic [ADDR_W:0]     o_words_loaded;
    logic [7:0]          o_checksum;
    logic [ADDR_W-1:0]   i_read_address;
    logic [DATA_W-1:0]   o_data;

    // Memory/loader side
    modport slave (
        input  i_load_start, i_load_base, i_load_len,
        input  i_byte_valid, i_byte, i_read_address,
        output o_byte_ready, o_busy, o_done,
        output o_words_loaded, o_checksum, o_data
    );

    // Boot controller / CPU side
    modport master (
        output i_load_start, i_load_base, i_load_len,
        output i_byte_valid, i_byte, i_read_address,
        input  o_byte_ready, o_busy, o_done,
        input  o_words_loaded, o_checksum, o_data
    );
endinterface

`default_nettype wire

// File: rtl/pmem_stream_loader.sv
//--------------------------------------------------------------------
// Module      : pmem_stream_loader
// Description : DATA_W x 2^ADDR_W program memory with a sequential
//               byte-stream loader (little-endian word assembly,
//               wrapping addresses, byte checksum) and one CPU read
//               port. Optional macro PMEM_REG_READ_EN selects a
//               registered (block-RAM style) read port; by default the
//               read port is combinational.
// Revision    : 1.0 - initial release
//--------------------------------------------------------------------
`default_nettype none

module pmem_stream_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst,
    pmem_stream_loader_if.slave bus
);
    localparam int BYTES  = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [ADDR_W-1:0]   base;
    logic [ADDR_W:0]     len;
    logic [LANE_W-1:0]   lane;
    logic [DATA_W-1:0]   hold;
    logic [ADDR_W:0]     words_loaded;
    logic [7:0]          checksum;

    logic                byte_ready;
    logic                busy;
    logic                done;
    logic                xfer;
    logic                commit;
    logic [ADDR_W:0]     words_next;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   word;
    logic [DATA_W-1:0]   rd_data;

    logic [DATA_W-1:0]   mem [DEPTH];

    // The committed word is the held lower lanes with the current byte on top
    generate
        if (BYTES > 1) begin : g_word_multi
            assign word = {bus.i_byte, hold[DATA_W-9:0]};
        end else begin : g_word_single
            assign word = bus.i_byte;
        end
    endgenerate

    assign words_next = words_loaded + (ADDR_W + 1)'(1);
    // Natural truncation to ADDR_W bits gives the wrap past DEPTH-1
    assign wr_addr    = base + words_loaded[ADDR_W-1:0];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and handshake/status decode
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        xfer       = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_load_start) begin
                    state_next = (bus.i_load_len != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                xfer       = bus.i_byte_valid;
                commit     = bus.i_byte_valid && (lane == LAST_LANE);
                if (commit && (words_next == len)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Load datapath: start latching, lane assembly, counters and checksum
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            base         <= '0;
            len          <= '0;
            lane         <= '0;
            hold         <= '0;
            words_loaded <= '0;
            checksum     <= '0;
        end else begin
            if ((state == IDLE) && bus.i_load_start) begin
                base         <= bus.i_load_base;
                len          <= bus.i_load_len;
                lane         <= '0;
                words_loaded <= '0;
                checksum     <= '0;
            end
            if (xfer) begin
                checksum          <= checksum + bus.i_byte;
                hold[lane*8 +: 8] <= bus.i_byte;
                lane              <= (lane == LAST_LANE) ? '0 : lane + LANE_W'(1);
            end
            if (commit) begin
                words_loaded <= words_next;
            end
        end
    end

    // Memory write port; the array itself is never reset
    always_ff @(posedge i_clk) begin
        if (commit && !i_rst) begin
            mem[wr_addr] <= word;
        end
    end

`ifdef PMEM_REG_READ_EN
    // Registered fetch: one-cycle latency, old data during a same-address write
    always_ff @(posedge i_clk) begin
        if (i_rst) rd_data <= '0;
        else       rd_data <= mem[bus.i_read_address];
    end
`else
    // Combinational fetch keeps the existing zero-latency CPU timing
    assign rd_data = mem[bus.i_read_address];
`endif

    assign bus.o_byte_ready   = byte_ready;
    assign bus.o_busy         = busy;
    assign bus.o_done         = done;
    assign bus.o_words_loaded = words_loaded;
    assign bus.o_checksum     = checksum;
    assign bus.o_data         = rd_data;

endmodule

`default_nettype wire

// File: tb/tb_pmem_stream_loader.sv
//--------------------------------------------------------------------
// Module      : tb_pmem_stream_loader
// Description : Directed self-checking bench for pmem_stream_loader.
// Revision    : 1.0 - initial release
//--------------------------------------------------------------------
`default_nettype none

module tb_pmem_stream_loader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pmem_stream_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    pmem_stream_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
        bus.i_load_start = 1'b1;
        bus.i_load_base  = base;
        bus.i_load_len   = len;
        tick();
        bus.i_load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_byte_valid = 1'b1;
        bus.i_byte       = b;
        tick();
        bus.i_byte_valid = 1'b0;
    endtask

    // Read port sampled after one edge so it works for both read styles
    task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        bus.i_read_address = a;
        tick();
        check(tag, 32'(bus.o_data), 32'(exp));
    endtask

    task automatic check_idle_status(input string tag, input logic [ADDR_W:0] words, input logic [7:0] sum);
        check({tag, "_busy"},  32'(bus.o_busy), 32'd0);
        check({tag, "_ready"}, 32'(bus.o_byte_ready), 32'd0);
        check({tag, "_done"},  32'(bus.o_done), 32'd0);
        check({tag, "_words"}, 32'(bus.o_words_loaded), 32'(words));
        check({tag, "_sum"},   32'(bus.o_checksum), 32'(sum));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.i_load_start   = 1'b0;
        bus.i_load_base    = '0;
        bus.i_load_len     = '0;
        bus.i_byte_valid   = 1'b0;
        bus.i_byte         = '0;
        bus.i_read_address = '0;
        tick();
        tick();
`ifdef PMEM_REG_READ_EN
        check("rst_data", 32'(bus.o_data), 32'd0);
`endif
        rst = 1'b0;
        check_idle_status("rst", '0, 8'h00);

        // Basic two-word load with continuous bytes
        bus.i_read_address = 10'h010;
        start(10'h010, 11'd2);
        check("t1_busy",  32'(bus.o_busy), 32'd1);
        check("t1_ready", 32'(bus.o_byte_ready), 32'd1);
        send(8'h34);
        send(8'h12);
`ifndef PMEM_REG_READ_EN
        check("t1_fresh_comb", 32'(bus.o_data), 32'h1234);
`endif
        check("t1_words_mid", 32'(bus.o_words_loaded), 32'd1);
        send(8'hCD);
`ifdef PMEM_REG_READ_EN
        check("t1_fresh_reg", 32'(bus.o_data), 32'h1234);
`endif
        send(8'hAB);
        check("t1_done",  32'(bus.o_done), 32'd1);
        check("t1_busy0", 32'(bus.o_busy), 32'd0);
        check("t1_rdy0",  32'(bus.o_byte_ready), 32'd0);
        check("t1_words", 32'(bus.o_words_loaded), 32'd2);
        check("t1_sum",   32'(bus.o_checksum), 32'hBE);
        tick();
        check_idle_status("t1_after", 11'd2, 8'hBE);
        rd("t1_m10", 10'h010, 16'h1234);
        rd("t1_m11", 10'h011, 16'hABCD);

        // Address wrap, with a start pulse during LOAD that must be ignored
        start(10'h3FF, 11'd2);
        bus.i_load_start = 1'b1;
        bus.i_load_base  = 10'h100;
        bus.i_load_len   = 11'd1;
        send(8'h01);
        bus.i_load_start = 1'b0;
        send(8'h00);
        check("t2_busy_mid", 32'(bus.o_busy), 32'd1);
        send(8'h02);
        send(8'h00);
        check("t2_done",  32'(bus.o_done), 32'd1);
        check("t2_words", 32'(bus.o_words_loaded), 32'd2);
        check("t2_sum",   32'(bus.o_checksum), 32'h03);
        rd("t2_m3ff", 10'h3FF, 16'h0001);
        rd("t2_m000", 10'h000, 16'h0002);

        // Source-side gaps: valid toggles 1,0,1,0
        start(10'h020, 11'd2);
        send(8'h34);
        tick();
        check("t3_ready_gap", 32'(bus.o_byte_ready), 32'd1);
        send(8'h12);
        tick();
        send(8'hCD);
        tick();
        check("t3_words_gap", 32'(bus.o_words_loaded), 32'd1);
        send(8'hAB);
        check("t3_done",  32'(bus.o_done), 32'd1);
        check("t3_words", 32'(bus.o_words_loaded), 32'd2);
        check("t3_sum",   32'(bus.o_checksum), 32'hBE);
        rd("t3_m20", 10'h020, 16'h1234);
        rd("t3_m21", 10'h021, 16'hABCD);

        // Zero-length load; a valid byte offered meanwhile is not consumed
        bus.i_byte_valid = 1'b1;
        bus.i_byte       = 8'h77;
        start(10'h030, 11'd0);
        check("t4_done",  32'(bus.o_done), 32'd1);
        check("t4_ready", 32'(bus.o_byte_ready), 32'd0);
        check("t4_busy",  32'(bus.o_busy), 32'd0);
        check("t4_words", 32'(bus.o_words_loaded), 32'd0);
        tick();
        bus.i_byte_valid = 1'b0;
        check_idle_status("t4_after", '0, 8'h00);

        // Known content at 0x041 before the interrupted load
        start(10'h041, 11'd1);
        send(8'h55);
        send(8'h66);
        tick();
        // Reset after three bytes of a two-word load
        start(10'h040, 11'd2);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_status("t5_rst", '0, 8'h00);
        rd("t5_m40", 10'h040, 16'h2211);
        rd("t5_m41", 10'h041, 16'h6655);
        // New load after reset must start at lane 0
        start(10'h050, 11'd1);
        send(8'h78);
        send(8'h56);
        check("t5_done",  32'(bus.o_done), 32'd1);
        check("t5_words", 32'(bus.o_words_loaded), 32'd1);
        check("t5_sum",   32'(bus.o_checksum), 32'hCE);
        rd("t5_m50", 10'h050, 16'h5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
